// File: rtl/hex_dump_pkg.sv
// Shared types and constants for the hex dump sequencer: frame FSM states,
// ASCII framing bytes and the nibble-to-ASCII mapping.
package hex_dump_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLabel,
        StHex,
        StCr,
        StLf
    } state_e;

    localparam logic [7:0]  ASCII_CR         = 8'h0D;
    localparam logic [7:0]  ASCII_LF         = 8'h0A;
    localparam logic [7:0]  ASCII_LABEL_BASE = 8'h41;
    localparam int unsigned HEX_CHARS        = 8;

    // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/bin_to_hex_ascii.sv
// Converts a 32-bit word into eight ASCII hex characters; the most significant
// nibble lands in bits [63:56].
module bin_to_hex_ascii
    import hex_dump_pkg::*;
(
    input  logic [31:0] bin,
    output logic [63:0] ascii
);

    for (genvar i = 0; i < HEX_CHARS; i++) begin : g_nib
        assign ascii[8*i +: 8] = hex_char(bin[4*i +: 4]);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one above ptr and wraps,
// returning a one-hot winner and its index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    int unsigned        cand;
    logic [IDX_W-1:0]   cand_idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid            = 1'b1;
                winner[cand_idx] = 1'b1;
                winner_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/hex_dump_sequencer.sv
// Arbitrates debug requesters onto one hex converter and streams each captured
// word to the UART as "[label] 8 hex chars CR LF", one byte per handshake.
module hex_dump_sequencer
    import hex_dump_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter bit          EMIT_LABEL = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    busy,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [31:0]        word_q, word_d;
    logic [2:0]         char_idx_q, char_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic [NUM_REQ-1:0] arb_winner;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [63:0]        ascii;
    logic               xfer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .ptr        (ptr_q),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .valid      (arb_valid)
    );

    bin_to_hex_ascii u_hex (
        .bin   (word_q),
        .ascii (ascii)
    );

    assign xfer = tx_valid & tx_ready;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        char_idx_d = char_idx_q;
        ptr_d      = ptr_q;
        grant_d    = '0;
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_d    = arb_winner;
                    ptr_d      = arb_idx;
                    word_d     = req_data[{arb_idx, 5'b00000} +: 32];
                    char_idx_d = '0;
                    state_d    = EMIT_LABEL ? StLabel : StHex;
                end
            end
            StLabel: if (xfer) state_d = StHex;
            StHex: begin
                if (xfer) begin
                    if (char_idx_q == 3'(HEX_CHARS - 1)) begin
                        state_d = StCr;
                    end else begin
                        char_idx_d = char_idx_q + 3'd1;
                    end
                end
            end
            StCr:    if (xfer) state_d = StLf;
            StLf:    if (xfer) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend on registered state only, so tx_valid never sees tx_ready.
    always_comb begin
        tx_valid = (state_q != StIdle);
        busy     = (state_q != StIdle);
        grant    = grant_q;
        case (state_q)
            StLabel: tx_data = ASCII_LABEL_BASE + 8'(ptr_q);
            StHex:   tx_data = ascii[{~char_idx_q, 3'b000} +: 8];
            StCr:    tx_data = ASCII_CR;
            StLf:    tx_data = ASCII_LF;
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            word_q     <= '0;
            char_idx_q <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            char_idx_q <= char_idx_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
        end
    end

endmodule

// File: tb/tb_hex_dump_sequencer.sv
// Self-checking bench: directed frames plus randomized requests and backpressure,
// compared against a frame/arbitration model built from plain arithmetic.
module tb_hex_dump_sequencer;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_a = '0;
    logic [N-1:0]   req_b = '0;
    logic [N*32-1:0] req_data = '0;
    logic           tx_ready = 1'b0;

    logic [N-1:0]   grant_a, grant_b;
    logic           busy_a, busy_b, tx_valid_a, tx_valid_b;
    logic [7:0]     tx_data_a, tx_data_b;

    int n_checks = 0;
    int n_fails  = 0;
    int ptr_a    = N - 1;
    int ptr_b    = N - 1;
    int rdy_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: random
    bit scramble = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    hex_dump_sequencer #(.NUM_REQ(N), .EMIT_LABEL(1'b1)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .req      (req_a),
        .req_data (req_data),
        .grant    (grant_a),
        .busy     (busy_a),
        .tx_data  (tx_data_a),
        .tx_valid (tx_valid_a),
        .tx_ready (tx_ready)
    );

    hex_dump_sequencer #(.NUM_REQ(N), .EMIT_LABEL(1'b0)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .req      (req_b),
        .req_data (req_data),
        .grant    (grant_b),
        .busy     (busy_b),
        .tx_data  (tx_data_b),
        .tx_valid (tx_valid_b),
        .tx_ready (tx_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic make_frame(input logic [31:0] w, input int idx, input bit label);
        int unsigned nib;
        exp_q.delete();
        if (label) exp_q.push_back(8'(65 + idx));
        for (int k = 0; k < 8; k++) begin
            nib = (w >> (28 - 4 * k)) & 32'hF;
            exp_q.push_back((nib < 10) ? 8'(48 + nib) : 8'(55 + nib));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        req_data[32*i +: 32] = w;
    endtask

    function automatic logic pick_ready(input int cyc);
        case (rdy_mode)
            1:       return (cyc % 3) == 0;
            2:       return $urandom_range(0, 3) != 0;
            default: return 1'b1;
        endcase
    endfunction

    // Expects a grant at the next negedge, then the whole frame, then one idle cycle.
    task automatic run_frame(input bit inst, input bit drop);
        logic [N-1:0] r;
        logic [N-1:0] g;
        int p, win, k, cyc;
        r   = inst ? req_b : req_a;
        p   = inst ? ptr_b : ptr_a;
        win = rr_pick(r, p);
        if (win < 0) begin
            check("model_no_request", 0, 1);
            return;
        end
        make_frame(req_data[32*win +: 32], win, !inst);
        if (inst) ptr_b = win; else ptr_a = win;
        g = '0;
        for (int c = 0; c < 4 && g == '0; c++) begin
            @(negedge clk);
            g = inst ? grant_b : grant_a;
        end
        check("grant", g, 64'(1) << win);
        if (drop) begin
            if (inst) req_b[win] = 1'b0; else req_a[win] = 1'b0;
        end
        if (scramble) req_data = {$urandom, $urandom, $urandom, $urandom};
        k   = 0;
        cyc = 0;
        while (k < exp_q.size() && cyc < 400) begin
            if (cyc > 0) begin
                @(negedge clk);
                check("grant_pulse", inst ? grant_b : grant_a, 0);
            end
            check("tx_valid", inst ? tx_valid_b : tx_valid_a, 1);
            check("busy", inst ? busy_b : busy_a, 1);
            check($sformatf("byte%0d", k), inst ? tx_data_b : tx_data_a, exp_q[k]);
            tx_ready = pick_ready(cyc);
            if (tx_ready) k++;
            cyc++;
        end
        check("frame_complete", k, exp_q.size());
        @(negedge clk);
        check("idle_valid", inst ? tx_valid_b : tx_valid_a, 0);
        check("idle_busy", inst ? busy_b : busy_a, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_grant", {grant_a, grant_b}, 0);
        check("rst_busy", {busy_a, busy_b}, 0);
        check("rst_valid", {tx_valid_a, tx_valid_b}, 0);
        check("rst_data", {tx_data_a, tx_data_b}, 0);
        rst   = 1'b0;
        ptr_a = N - 1;
        ptr_b = N - 1;
    endtask

    initial begin
        // Reset values and single request
        do_reset();
        set_word(0, 32'hDEADBEEF);
        req_a = 4'b0001;
        run_frame(0, 1);

        // Backpressure with 1,0,0 ready pattern
        set_word(0, 32'h0123ABCD);
        req_a    = 4'b0001;
        rdy_mode = 1;
        run_frame(0, 1);
        rdy_mode = 0;

        // Round-robin with all requests held
        do_reset();
        for (int i = 0; i < N; i++) set_word(i, 32'(i));
        req_a = 4'b1111;
        for (int i = 0; i < 5; i++) run_frame(0, 0);

        // Skip idle requesters: expect 2 then 0
        req_a = 4'b0101;
        run_frame(0, 0);
        run_frame(0, 0);
        req_a = 4'b0000;
        @(negedge clk);

        // Reset in the middle of the hex characters
        set_word(0, 32'h89ABCDEF);
        req_a    = 4'b0001;
        tx_ready = 1'b1;
        @(negedge clk);
        check("mid_grant", grant_a, 4'b0001);
        req_a = 4'b0000;
        repeat (4) @(negedge clk);
        check("mid_hex3", tx_data_a, 8'h42);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", tx_valid_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_grant", grant_a, 0);
        check("mid_rst_data", tx_data_a, 0);
        rst   = 1'b0;
        ptr_a = N - 1;
        ptr_b = N - 1;
        req_a = 4'b0001;
        run_frame(0, 1);

        // Randomized requests, words, backpressure and post-capture data changes
        rdy_mode = 2;
        scramble = 1;
        for (int it = 0; it < 16; it++) begin
            req_data = {$urandom, $urandom, $urandom, $urandom};
            req_a    = 4'($urandom_range(1, 15));
            run_frame(0, 1'($urandom_range(0, 1)));
        end
        req_a = '0;

        // Instance without label
        rdy_mode = 0;
        scramble = 0;
        set_word(0, 32'h00000000);
        req_b = 4'b0001;
        run_frame(1, 1);
        rdy_mode = 2;
        scramble = 1;
        for (int it = 0; it < 4; it++) begin
            req_data = {$urandom, $urandom, $urandom, $urandom};
            req_b    = 4'($urandom_range(1, 15));
            run_frame(1, 1);
        end
        req_b = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
